dmem_responder: RTL and testbench

//   Memory-side (responder) end of the core's load/store port: word-organised data RAM with a

---
 rtl/dmem_responder_pkg.sv | 23 ++
 rtl/dmem_responder_lane_ctrl.sv | 61 ++++++
 rtl/dmem_responder.sv | 149 ++++++++++++++
 tb/tb_dmem_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared encodings and request payload type for the data-memory responder.
package dmem_responder_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Responder FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    // Request fields captured at the accept handshake
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        is_unsigned;
    } dmem_req_t;

endpackage

// File: rtl/dmem_responder_lane_ctrl.sv
// Byte-lane steering for stores and lane select plus extension for loads.
module dmem_lane_ctrl
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en_c,
    output logic [31:0] wword_c,
    output logic [31:0] rdata_c,
    output logic        misalign_c
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    // Pick the addressed byte/half out of the raw word
    always_comb begin
        sel_b = rword[7:0];
        case (addr_lo)
            2'd0:    sel_b = rword[7:0];
            2'd1:    sel_b = rword[15:8];
            2'd2:    sel_b = rword[23:16];
            default: sel_b = rword[31:24];
        endcase
        sel_h = addr_lo[1] ? rword[31:16] : rword[15:0];
    end

    // Enables, replicated write data, extended load data and alignment check per size
    always_comb begin
        byte_en_c  = 4'b0000;
        wword_c    = 32'h0000_0000;
        rdata_c    = 32'h0000_0000;
        misalign_c = 1'b0;
        case (size)
            SIZE_BYTE: begin
                byte_en_c = 4'b0001 << addr_lo;
                wword_c   = {4{wdata[7:0]}};
                rdata_c   = is_unsigned ? {24'h00_0000, sel_b} : {{24{sel_b[7]}}, sel_b};
            end
            SIZE_HALF: begin
                misalign_c = addr_lo[0];
                byte_en_c  = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword_c    = {2{wdata[15:0]}};
                rdata_c    = is_unsigned ? {16'h0000, sel_h} : {{16{sel_h[15]}}, sel_h};
            end
            SIZE_WORD: begin
                misalign_c = (addr_lo != 2'b00);
                byte_en_c  = 4'b1111;
                wword_c    = wdata;
                rdata_c    = rword;
            end
            default: begin
                misalign_c = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the LSU port: one request at a time, programmable latency.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned WAIT_LAST = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    logic [1:0]            state, next_state;
    logic [CNT_W-1:0]      cnt;
    dmem_req_t             req_in_c, lat, cur;
    logic                  accept_c, enter_resp_c, range_err_c, err_c;
    logic [DEPTH_LOG2-1:0] idx_c;
    logic [3:0]            lane_be_c;
    logic [31:0]           lane_wword_c, lane_rdata_c, rword_c;
    logic                  lane_misalign_c;
    logic [31:0]           mem [DEPTH];

    assign accept_c = req_valid && req_ready;

    // Live request fields; used directly when the response is formed on the accept edge
    always_comb begin
        req_in_c.we          = req_we;
        req_in_c.addr        = req_addr;
        req_in_c.wdata       = req_wdata;
        req_in_c.size        = req_size;
        req_in_c.is_unsigned = req_unsigned;
        cur = (state == ST_IDLE) ? req_in_c : lat;
    end

    // Address decode and error qualification for the request being serviced
    always_comb begin
        idx_c       = cur.addr[DEPTH_LOG2+1:2];
        range_err_c = (cur.addr >> (DEPTH_LOG2 + 2)) != 32'd0;
        err_c       = lane_misalign_c || range_err_c;
        rword_c     = mem[idx_c];
    end

    dmem_lane_ctrl u_lane (
        .size        (cur.size),
        .addr_lo     (cur.addr[1:0]),
        .is_unsigned (cur.is_unsigned),
        .wdata       (cur.wdata),
        .rword       (rword_c),
        .byte_en_c   (lane_be_c),
        .wword_c     (lane_wword_c),
        .rdata_c     (lane_rdata_c),
        .misalign_c  (lane_misalign_c)
    );

    // Next-state logic; enter_resp_c marks the edge where the access is performed
    always_comb begin
        next_state   = state;
        enter_resp_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    if (WAIT_CYCLES == 0) begin
                        next_state   = ST_RESP;
                        enter_resp_c = 1'b1;
                    end else begin
                        next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == CNT_W'(WAIT_LAST)) begin
                    next_state   = ST_RESP;
                    enter_resp_c = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State, wait counter and request latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            lat   <= '0;
        end else begin
            state <= next_state;
            if (state == ST_WAIT && next_state == ST_WAIT) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if (accept_c) begin
                lat <= req_in_c;
            end
        end
    end

    // Registered handshake and response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            rsp_err   <= 1'b0;
        end else begin
            req_ready <= (next_state == ST_IDLE);
            rsp_valid <= (next_state == ST_RESP);
            if (enter_resp_c) begin
                rsp_err   <= err_c;
                rsp_rdata <= (cur.we || err_c) ? 32'h0000_0000 : lane_rdata_c;
            end else if (next_state != ST_RESP) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'h0000_0000;
            end
        end
    end

    // Store commit on the edge entering RESP; contents are never reset
    always_ff @(posedge clk) begin
        if (enter_resp_c && cur.we && !err_c) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_be_c[b]) begin
                    mem[idx_c][8*b +: 8] <= lane_wword_c[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed loads/stores, errors, stalls and resets.
module tb_dmem_responder;

    localparam int unsigned TB_WAIT  = 2;
    localparam int unsigned TB_DEPTH = 10;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    bit   in_rsp = 1'b0;

    dmem_responder #(
        .DEPTH_LOG2  (TB_DEPTH),
        .WAIT_CYCLES (TB_WAIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one request, push its expected response when the handshake is certain
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns,
                         input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   n;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        e.rd  = exp_rd;
        e.err = exp_err;
        e.acc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = 1'b1;
        req_addr     = 32'hFFFF_FFFF;
        req_wdata    = 32'hA5A5_A5A5;
        req_size     = SZ_X;
        req_unsigned = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic wait_rsp_valid();
        int n;
        n = 0;
        @(negedge clk);
        #1;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!rsp_valid) chk("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    endtask

    // Monitor: compare every presented response against the head of the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                in_rsp = 1'b0;
            end else if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    if (!in_rsp) chk("latency", 32'(cyc), 32'(sb[0].acc + int'(TB_WAIT) + 1));
                    chk("rsp_rdata", rsp_rdata, sb[0].rd);
                    chk("rsp_err", 32'(rsp_err), 32'(sb[0].err));
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        in_rsp = 1'b0;
                    end else begin
                        in_rsp = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] exp_after_wait_reset;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_size     = SZ_W;
        req_unsigned = 1'b0;
        rsp_ready    = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // Word store then load
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, SZ_W, 1'b0, 32'h0, 1'b0);
        issue(1'b0, 32'h10, 32'h0,         SZ_W, 1'b0, 32'hDEAD_BEEF, 1'b0);
        drain();

        // Byte store into lane 1 and sub-word loads
        issue(1'b1, 32'h11, 32'hFFFF_FF80, SZ_B, 1'b0, 32'h0, 1'b0);
        issue(1'b0, 32'h10, 32'h0, SZ_W, 1'b0, 32'hDEAD_80EF, 1'b0);
        issue(1'b0, 32'h11, 32'h0, SZ_B, 1'b0, 32'hFFFF_FF80, 1'b0);
        issue(1'b0, 32'h11, 32'h0, SZ_B, 1'b1, 32'h0000_0080, 1'b0);
        issue(1'b0, 32'h13, 32'h0, SZ_B, 1'b0, 32'hFFFF_FFDE, 1'b0);
        issue(1'b0, 32'h12, 32'h0, SZ_H, 1'b0, 32'hFFFF_DEAD, 1'b0);
        issue(1'b0, 32'h10, 32'h0, SZ_H, 1'b1, 32'h0000_80EF, 1'b0);
        drain();

        // Errors: misaligned half, illegal size, out of range (incl. aliasing store)
        issue(1'b1, 32'h13,   32'h0000_1234, SZ_H, 1'b0, 32'h0, 1'b1);
        issue(1'b0, 32'h10,   32'h0,         SZ_X, 1'b0, 32'h0, 1'b1);
        issue(1'b0, 32'h1002, 32'h0,         SZ_W, 1'b0, 32'h0, 1'b1);
        issue(1'b1, 32'h1010, 32'h0,         SZ_W, 1'b0, 32'h0, 1'b1);
        issue(1'b0, 32'h1010, 32'h0,         SZ_W, 1'b0, 32'h0, 1'b1);
        issue(1'b0, 32'h10,   32'h0,         SZ_W, 1'b0, 32'hDEAD_80EF, 1'b0);
        drain();

        // Back-pressure: hold the response for five cycles while a stray request is offered
        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, SZ_W, 1'b0, 32'hDEAD_80EF, 1'b0);
        wait_rsp_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 32'h10;
            req_wdata = 32'h0;
            req_size  = SZ_W;
            #1;
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("release_req_ready", 32'(req_ready), 32'd1);
        chk("release_rsp_valid", 32'(rsp_valid), 32'd0);
        drain();
        issue(1'b1, 32'h12, 32'h0000_7777, SZ_H, 1'b0, 32'h0, 1'b0);
        issue(1'b0, 32'h10, 32'h0,         SZ_W, 1'b0, 32'h7777_80EF, 1'b0);
        drain();

        // Reset while the store is still waiting: store dropped
        issue(1'b1, 32'h20, 32'h1122_3344, SZ_W, 1'b0, 32'h0, 1'b0);
        drain();
        issue(1'b1, 32'h20, 32'h0000_0055, SZ_W, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        #1;
        chk_reset_outputs("rst_wait");
        @(negedge clk);
        reset = 1'b0;
        exp_after_wait_reset = (TB_WAIT == 0) ? 32'h0000_0055 : 32'h1122_3344;
        issue(1'b0, 32'h20, 32'h0, SZ_W, 1'b0, exp_after_wait_reset, 1'b0);
        drain();

        // Reset while the response is held: store already committed
        rsp_ready = 1'b0;
        issue(1'b1, 32'h20, 32'h0000_0055, SZ_W, 1'b0, 32'h0, 1'b0);
        wait_rsp_valid();
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        #1;
        chk_reset_outputs("rst_resp");
        @(negedge clk);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        issue(1'b0, 32'h20, 32'h0, SZ_W, 1'b0, 32'h0000_0055, 1'b0);
        drain();

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
